iir_cascade: RTL and testbench
==============================

// Module: iir_cascade
// PURPOSE
//   Parametrised cascade of SECTIONS first-order IIR sections: y = a0*x + a1*x[n-1] - b1*y[n-1].
//   Signed fixed point; one time-multiplexed multiplier-accumulator serves all sections.
//   Runtime-writable/readable coefficient register file; valid/ready sample stream in and out.
//   Sits between the sample source and the downstream datapath; replaces fixed 3-stage filter chains.
// PARAMETERS
//   DATA_W    16  sample/coefficient width, two's complement
//   FRAC_W    11  fractional bits (Q5.11 at default; 1.0 = 0x0800)
//   SECTIONS  3   number of cascaded sections, 1..16
//   ADDR_W    8   coefficient address width; requires 3*SECTIONS <= 2**ADDR_W
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-low; clears all state and coefficients
//   cfg_we     in   1        coefficient write strobe
//   cfg_addr   in   ADDR_W   addr 3*s+0=a0, 3*s+1=a1, 3*s+2=b1 of section s
//   cfg_wdata  in   DATA_W   coefficient write data
//   cfg_rdata  out  DATA_W   combinational readback of cfg_addr; 0 if out of range
//   flush      in   1        synchronous clear of filter history; aborts in-flight sample
//   in_valid   in   1        input sample valid
//   in_data    in   DATA_W   input sample
//   in_ready   out  1        block can accept a sample
//   out_valid  out  1        output sample valid, held until accepted
//   out_data   out  DATA_W   final-section output
//   out_ready  in   1        downstream accepts output
//   sat_flag   out  1        sticky overflow indicator
// BEHAVIOUR
//   Reset: coefficients, x1[s], y1[s], out_data = 0; out_valid = 0; in_ready = 1; sat_flag = 0; FSM IDLE.
//   FSM IDLE -> MAC -> OUT. IDLE: in_ready=1; accept on in_valid&&in_ready, latch in_data, s=0, go MAC.
//   MAC: 3 cycles per section (products a0*x, a1*x1[s], b1*y1[s] into ACC of 2*DATA_W+2 bits).
//     3rd cycle: y = ACC >>> FRAC_W (arithmetic, truncate toward -inf), reduced to DATA_W;
//     x1[s]<=x, y1[s]<=y, x<=y, s++. After s=SECTIONS-1: out_data<=y, go OUT.
//   Latency: out_valid rises 3*SECTIONS+1 cycles after the accepting edge (10 at default).
//   OUT: out_valid=1, out_data stable; on out_ready go IDLE. in_ready=0 in MAC and OUT.
//   flush: zero all x1/y1, drop in-flight sample, out_valid<=0, go IDLE; coefficients kept; wins over all.
//   cfg_we: applied any state; a write in the cycle a coefficient is read takes effect next use.
//     Out-of-range address: write ignored. sat_flag cleared only by reset.
//   Reset mid-operation: immediate return to reset state, no partial output.
// CONFIGURATION
//   IIR_CASCADE_SAT_EN defined: y clamps to [-2**(DATA_W-1), 2**(DATA_W-1)-1]; any clamp sets sat_flag.
//   Not defined: y keeps low DATA_W bits (wrap); sat_flag tied 0.
// STRUCTURE
//   Package iir_pkg: DATA_W/FRAC_W defaults, coefficient offsets (A0=0,A1=1,B1=2), FSM state encoding.
//   Sub-module iir_mac: signed multiply, accumulate/subtract, shift, saturate-or-wrap; FSM/regfile in top.
// TESTING
//   Passthrough: all a0=0x0800, a1=b1=0; in 0x0400 -> out 0x0400, out_valid 10 cycles after accept.
//   FIR tap: sec0 a1=0x0400, others passthrough; inputs 0x0800,0,0 -> outputs 0x0800,0x0400,0x0000.
//   Feedback: sec0 b1=0xFC00 (-0.5); impulse 0x0800 then zeros -> 0x0800,0x0400,0x0200,0x0100.
//   Overflow: sec0 a0=0x7FFF, in 0x7FFF -> SAT_EN: 0x7FFF, sat_flag=1; else 0xFFE0, sat_flag=0.
//   Backpressure/flush: out_ready=0 holds out_data, in_ready=0; flush mid-MAC -> no out_valid, next impulse matches fresh response.
//   Reset mid-MAC and cfg readback: reset drops out_valid, cfg_rdata=0; write/read addr 8 = 0x1234; addr 9 reads 0.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR cascade: default widths, coefficient slot
// offsets within a section, the controller state encoding and the MAC
// operation select.
package iir_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 11;

    // Coefficient slot offsets inside one section (address = 3*s + offset).
    localparam int COEF_A0 = 0;
    localparam int COEF_A1 = 1;
    localparam int COEF_B1 = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    typedef enum logic [1:0] {
        MAC_LOAD,
        MAC_ADD,
        MAC_SUB
    } mac_op_t;

endpackage

// File: rtl/iir_mac.sv
// Combinational multiply-accumulate slice shared by all cascade sections.
// Config macro: IIR_CASCADE_SAT_EN selects clamping instead of wrapping of
// the reduced result.
// Ports:
//   acc      in   current accumulator (2*DATA_W+2 bits, signed)
//   coef     in   coefficient operand
//   sample   in   sample operand
//   op       in   MAC_LOAD: acc_next = p, MAC_ADD: acc + p, MAC_SUB: acc - p
//   acc_next out  updated accumulator
//   y        out  acc_next >>> FRAC_W reduced to DATA_W (clamped or wrapped)
//   sat      out  reduction clamped this cycle (always 0 without SAT_EN)
module iir_mac
    import iir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ACC_W  = 2 * DATA_W + 2
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] coef,
    input  logic signed [DATA_W-1:0] sample,
    input  mac_op_t                  op,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic        [DATA_W-1:0] y,
    output logic                     sat
);

    // Bit that becomes the sign bit of y after the shift.
    localparam int HI_LSB = FRAC_W + DATA_W - 1;

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    always_comb begin
        // Low 2*DATA_W bits of the product of sign-extended operands equal the
        // signed product.
        prod     = {{DATA_W{coef[DATA_W-1]}}, coef} * {{DATA_W{sample[DATA_W-1]}}, sample};
        prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        unique case (op)
            MAC_LOAD: acc_next = prod_ext;
            MAC_ADD:  acc_next = acc + prod_ext;
            MAC_SUB:  acc_next = acc - prod_ext;
            default:  acc_next = acc;
        endcase
    end

`ifdef IIR_CASCADE_SAT_EN
    logic [ACC_W-1-HI_LSB:0] hi;

    always_comb begin
        // Result fits when every bit from the output sign bit upward agrees.
        hi  = acc_next[ACC_W-1:HI_LSB];
        sat = 1'b0;
        y   = acc_next[HI_LSB:FRAC_W];
        if (hi != '0 && hi != '1) begin
            sat = 1'b1;
            y   = acc_next[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        y   = acc_next[HI_LSB:FRAC_W];
        sat = 1'b0;
    end
`endif

endmodule

// File: rtl/iir_cascade.sv
// Cascade of SECTIONS first-order IIR sections, y = a0*x + a1*x1 - b1*y1,
// evaluated by one time-multiplexed MAC (3 cycles per section).
// Config macro: IIR_CASCADE_SAT_EN (clamp results and drive sat_flag).
// Ports:
//   clk, reset (async, active-low)
//   cfg_we/cfg_addr/cfg_wdata  coefficient write (addr 3*s+{0:a0,1:a1,2:b1})
//   cfg_rdata                  combinational readback, 0 when out of range
//   flush                      clears filter history, aborts in-flight sample
//   in_valid/in_data/in_ready  input sample stream
//   out_valid/out_data/out_ready output sample stream
//   sat_flag                   sticky overflow indicator
module iir_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int SECTIONS = 3,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sat_flag
);

    localparam int ACC_W = 2 * DATA_W + 2;
    localparam int NCOEF = 3 * SECTIONS;
    localparam int CW    = $clog2(NCOEF);
    localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int SD    = 1 << SW;
    localparam logic [ADDR_W:0] NCOEF_A = (ADDR_W + 1)'(NCOEF);
    localparam logic [SW-1:0]   LAST_S  = SW'(SECTIONS - 1);

    logic signed [DATA_W-1:0] coef [NCOEF];
    logic signed [DATA_W-1:0] x1 [SD];
    logic signed [DATA_W-1:0] y1 [SD];

    state_t                   state;
    logic [1:0]               phase;
    logic [SW-1:0]            s;
    logic [CW-1:0]            ci;
    logic signed [DATA_W-1:0] x;
    logic signed [ACC_W-1:0]  acc;

    mac_op_t                  mac_op;
    logic signed [DATA_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_sample;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        mac_y;
    logic                     mac_sat;
    logic                     cfg_in_range;

    assign cfg_in_range = ({1'b0, cfg_addr} < NCOEF_A);
    assign in_ready     = (state == ST_IDLE) && !flush;

    // Coefficient register file; writes land regardless of controller state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCOEF; i++) coef[i] <= '0;
        end else if (cfg_we && cfg_in_range) begin
            coef[cfg_addr[CW-1:0]] <= cfg_wdata;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        if (cfg_in_range) cfg_rdata = coef[cfg_addr[CW-1:0]];
    end

    // ci walks the coefficient file in step with (s, phase), avoiding 3*s+phase.
    always_comb begin
        mac_coef = coef[ci];
        unique case (phase)
            2'd0: begin mac_op = MAC_LOAD; mac_sample = x;     end
            2'd1: begin mac_op = MAC_ADD;  mac_sample = x1[s]; end
            default: begin mac_op = MAC_SUB; mac_sample = y1[s]; end
        endcase
    end

    iir_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc      (acc),
        .coef     (mac_coef),
        .sample   (mac_sample),
        .op       (mac_op),
        .acc_next (acc_next),
        .y        (mac_y),
        .sat      (mac_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            phase     <= '0;
            s         <= '0;
            ci        <= '0;
            x         <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            for (int unsigned i = 0; i < SD; i++) begin
                x1[i] <= '0;
                y1[i] <= '0;
            end
        end else if (flush) begin
            state     <= ST_IDLE;
            phase     <= '0;
            s         <= '0;
            ci        <= '0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < SD; i++) begin
                x1[i] <= '0;
                y1[i] <= '0;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x     <= in_data;
                        phase <= '0;
                        s     <= '0;
                        ci    <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    ci  <= ci + CW'(1);
                    if (phase == 2'(COEF_B1)) begin
                        x1[s]    <= x;
                        y1[s]    <= mac_y;
                        x        <= mac_y;
                        sat_flag <= sat_flag | mac_sat;
                        phase    <= '0;
                        if (s == LAST_S) begin
                            out_data <= mac_y;
                            state    <= ST_OUT;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                ST_OUT: begin
                    // One settling cycle before out_valid rises gives the
                    // 3*SECTIONS+1 latency from the accepting edge.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_cascade.sv
module tb_iir_cascade;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        sat_flag;

    int checks = 0;
    int errors = 0;

    iir_cascade #(
        .DATA_W   (16),
        .FRAC_W   (11),
        .SECTIONS (3),
        .ADDR_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic write_coef(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // All sections a0=1.0, a1=b1=0.
    task automatic set_passthrough();
        for (int s = 0; s < 3; s++) begin
            write_coef(8'(3*s),   16'h0800);
            write_coef(8'(3*s+1), 16'h0000);
            write_coef(8'(3*s+2), 16'h0000);
        end
    endtask

    // Sends one sample, waits (bounded) for the result and accepts it.
    // On timeout dout is X so any following comparison fails.
    task automatic run_sample(input logic [15:0] din, output logic [15:0] dout, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_data = din;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = out_valid ? out_data : 'x;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
        cfg_addr = 8'd0; #1;
        checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL reset_coef got %h want 0000", cfg_rdata); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [15:0] d;
        int lat;
        set_passthrough();
        do_flush();
        run_sample(16'h0400, d, lat);
        checks++; if (d !== 16'h0400) begin errors++; $display("FAIL pass_data got %h want 0400", d); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL pass_latency got %0d want 10", lat); end
    endtask

    task automatic test_fir_tap();
        logic [15:0] d;
        logic [15:0] stim [3] = '{16'h0800, 16'h0000, 16'h0000};
        logic [15:0] exp_y [3] = '{16'h0800, 16'h0400, 16'h0000};
        int lat;
        write_coef(8'd1, 16'h0400);
        do_flush();
        for (int i = 0; i < 3; i++) begin
            run_sample(stim[i], d, lat);
            checks++; if (d !== exp_y[i]) begin errors++; $display("FAIL fir_out%0d got %h want %h", i, d, exp_y[i]); end
        end
    endtask

    task automatic test_feedback();
        logic [15:0] d;
        logic [15:0] exp_y [4] = '{16'h0800, 16'h0400, 16'h0200, 16'h0100};
        int lat;
        write_coef(8'd1, 16'h0000);
        write_coef(8'd2, 16'hFC00);
        do_flush();
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 16'h0800 : 16'h0000, d, lat);
            checks++; if (d !== exp_y[i]) begin errors++; $display("FAIL fb_out%0d got %h want %h", i, d, exp_y[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_flush();
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0400;
        @(posedge clk);
        #1 in_data = 16'h7000; // stays valid but must not be taken while busy
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 16'h0400 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d got valid=%b data=%h ready=%b want 1 0400 0", i, out_valid, out_data, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [15:0] d;
        int lat;
        int seen;
        do_flush();
        run_sample(16'h0800, d, lat);
        checks++; if (d !== 16'h0800) begin errors++; $display("FAIL flush_first got %h want 0800", d); end
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        do_flush();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_output got %0d valid cycles want 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got in_ready=%b want 1", in_ready); end
        run_sample(16'h0800, d, lat);
        checks++; if (d !== 16'h0800) begin errors++; $display("FAIL flush_fresh got %h want 0800", d); end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        int lat;
        write_coef(8'd0, 16'h7FFF);
        write_coef(8'd2, 16'h0000);
        do_flush();
        run_sample(16'h7FFF, d, lat);
`ifdef IIR_CASCADE_SAT_EN
        checks++; if (d !== 16'h7FFF) begin errors++; $display("FAIL ovf_data got %h want 7fff", d); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL ovf_sat got %b want 1", sat_flag); end
`else
        checks++; if (d !== 16'hFFE0) begin errors++; $display("FAIL ovf_data got %h want ffe0", d); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL ovf_sat got %b want 0", sat_flag); end
`endif
    endtask

    task automatic test_reset_mid_cfg();
        int seen;
        write_coef(8'd8, 16'h1234);
        write_coef(8'd9, 16'h5555);
        @(negedge clk); cfg_addr = 8'd8; #1;
        checks++; if (cfg_rdata !== 16'h1234) begin errors++; $display("FAIL cfg_read8 got %h want 1234", cfg_rdata); end
        cfg_addr = 8'd9; #1;
        checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL cfg_read9 got %h want 0000", cfg_rdata); end
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0400;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; cfg_addr = 8'd8;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_state got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_data got %h want 0000", out_data); end
        checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL rst_mid_coef got %h want 0000", cfg_rdata); end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_output got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_passthrough();
        test_fir_tap();
        test_feedback();
        test_back_to_back();
        test_flush();
        test_overflow();
        test_reset_mid_cfg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
